// File: rtl/mem_io_ctrl_if.sv
// mem_io_ctrl_if: CPU memory bus plus external RAM port of the memory/IO controller.
//   mem_cmd    [1:0]  bus command (00 none, 01 read, 10 write, 11 none)
//   mem_addr   [8:0]  word address from the CPU
//   write_data [15:0] CPU write data
//   read_data  [15:0] read data returned to the CPU
//   ram_addr   [7:0]  RAM address
//   ram_we            RAM write enable
//   ram_wdata  [15:0] RAM write data
//   ram_rdata  [15:0] RAM read data (combinational-read RAM)
// master: the environment (CPU and RAM). slave: the controller.
interface mem_io_ctrl_if;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   modport master (
      output mem_cmd, mem_addr, write_data, ram_rdata,
      input  read_data, ram_addr, ram_we, ram_wdata
   );

   modport slave (
      input  mem_cmd, mem_addr, write_data, ram_rdata,
      output read_data, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: memory/IO controller behind the CPU memory bus. Steers accesses
// to RAM (0..RAM_TOP) or to LED/TLOAD/TCOUNT/TSTAT/SW registers, owns the
// switch synchronizer and a prescaled periodic countdown timer.
// Ports:
//   clk        system clock
//   reset      synchronous, active-low
//   bus        mem_io_ctrl_if.slave (CPU bus + RAM port)
//   sw [9:0]   asynchronous slide switches
//   led [7:0]  LED register
//   timer_irq  timer expired flag
//   bus_err    sticky illegal-access flag (only with MEM_IO_BUS_ERR_EN defined)
// Optional feature macro: MEM_IO_BUS_ERR_EN.
module mem_io_ctrl #(
   parameter int unsigned PRESCALE = 50,
   parameter logic [8:0]  RAM_TOP  = 9'h0FF
) (
   input  logic         clk,
   input  logic         reset,
   mem_io_ctrl_if.slave bus,
   input  logic [9:0]   sw,
   output logic [7:0]   led,
   output logic         timer_irq
`ifdef MEM_IO_BUS_ERR_EN
   ,
   output logic         bus_err
`endif
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [8:0] A_LED    = 9'h100;
   localparam logic [8:0] A_TLOAD  = 9'h101;
   localparam logic [8:0] A_TCOUNT = 9'h102;
   localparam logic [8:0] A_TSTAT  = 9'h103;
   localparam logic [8:0] A_SW     = 9'h140;

   typedef enum logic [1:0] {T_IDLE, T_RUN, T_EXPIRED} tstate_e;

   tstate_e       state_q, state_d;
   logic [7:0]    led_q, led_d;
   logic [15:0]   tload_q, tload_d;
   logic [15:0]   tcount_q, tcount_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          expired_q, expired_d;
   logic [9:0]    sw_meta_q, sw_meta_d;
   logic [9:0]    sw_sync_q, sw_sync_d;
   logic          berr_rd;

   logic          is_rd, is_wr, hit_ram, wr_reg;
   logic          wr_led, wr_tload, wr_tstat;
   logic          tick, expire_set;
   logic [15:0]   base;
   logic [15:0]   rdata;

`ifdef MEM_IO_BUS_ERR_EN
   logic          bus_err_q, bus_err_d;
   logic          mapped;
   assign berr_rd = bus_err_q;
   assign bus_err = bus_err_q;
`else
   assign berr_rd = 1'b0;
`endif

   // Decode and read mux
   always_comb begin
      is_rd    = (bus.mem_cmd == 2'b01);
      is_wr    = (bus.mem_cmd == 2'b10);
      hit_ram  = (bus.mem_addr <= RAM_TOP);
      wr_reg   = is_wr && !hit_ram;
      wr_led   = wr_reg && (bus.mem_addr == A_LED);
      wr_tload = wr_reg && (bus.mem_addr == A_TLOAD);
      wr_tstat = wr_reg && (bus.mem_addr == A_TSTAT);
      rdata    = '0;
      if (is_rd) begin
         if (hit_ram) begin
            rdata = bus.ram_rdata;
         end else begin
            case (bus.mem_addr)
               A_LED:    rdata = {8'h00, led_q};
               A_TLOAD:  rdata = tload_q;
               A_TCOUNT: rdata = tcount_q;
               A_TSTAT:  rdata = {13'h0000, berr_rd, (state_q != T_IDLE), expired_q};
               A_SW:     rdata = {6'h00, sw_sync_q};
               default:  rdata = '0;
            endcase
         end
      end
   end

   assign bus.read_data = rdata;
   assign bus.ram_addr  = bus.mem_addr[7:0];
   assign bus.ram_we    = is_wr && hit_ram;
   assign bus.ram_wdata = bus.write_data;
   assign led           = led_q;
   assign timer_irq     = expired_q;

   // Register file and timer next-state
   always_comb begin
      led_d      = wr_led   ? bus.write_data[7:0] : led_q;
      tload_d    = wr_tload ? bus.write_data      : tload_q;
      sw_meta_d  = sw;
      sw_sync_d  = sw_meta_q;
      state_d    = state_q;
      tcount_d   = tcount_q;
      presc_d    = presc_q;
      expire_set = 1'b0;
      tick       = (presc_q == PW'(PRESCALE - 1));
      base       = tcount_q;
      case (state_q)
         T_IDLE: begin
            if (wr_tstat && bus.write_data[1]) begin
               presc_d = '0;
               if (tload_q == '0) begin
                  tcount_d   = '0;
                  expire_set = 1'b1;
                  state_d    = T_EXPIRED;
               end else begin
                  tcount_d = tload_q;
                  state_d  = T_RUN;
               end
            end
         end
         T_RUN, T_EXPIRED: begin
            if (wr_tstat && !bus.write_data[1]) begin
               state_d = T_IDLE;
            end else begin
               // EXPIRED lasts one cycle: it counts exactly like RUN but from
               // the reloaded TLOAD, so the tick period is never stretched.
               base     = (state_q == T_EXPIRED) ? tload_q : tcount_q;
               presc_d  = tick ? '0 : presc_q + PW'(1);
               tcount_d = base;
               state_d  = T_RUN;
               if (tick) begin
                  if (base <= 16'd1) begin
                     tcount_d   = '0;
                     expire_set = 1'b1;
                     state_d    = T_EXPIRED;
                  end else begin
                     tcount_d = base - 16'd1;
                  end
               end
            end
         end
         default: state_d = T_IDLE;
      endcase
      // Setting the flag wins over a same-cycle software clear.
      if (expire_set) begin
         expired_d = 1'b1;
      end else if (wr_tstat && bus.write_data[0]) begin
         expired_d = 1'b0;
      end else begin
         expired_d = expired_q;
      end
`ifdef MEM_IO_BUS_ERR_EN
      mapped    = hit_ram || (bus.mem_addr inside {A_LED, A_TLOAD, A_TCOUNT, A_TSTAT, A_SW});
      bus_err_d = bus_err_q
                  || ((is_rd || is_wr) && !mapped)
                  || (wr_reg && ((bus.mem_addr == A_TCOUNT) || (bus.mem_addr == A_SW)));
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= T_IDLE;
         led_q     <= '0;
         tload_q   <= '0;
         tcount_q  <= '0;
         presc_q   <= '0;
         expired_q <= 1'b0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
`ifdef MEM_IO_BUS_ERR_EN
         bus_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         led_q     <= led_d;
         tload_q   <= tload_d;
         tcount_q  <= tcount_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
`ifdef MEM_IO_BUS_ERR_EN
         bus_err_q <= bus_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: scoreboard bench for mem_io_ctrl. A driver issues one bus
// cycle per clock, computes the expected outputs from a behavioural model and
// queues them; a monitor pops and compares at each falling edge.
module tb_mem_io_ctrl;
   localparam int unsigned P = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] sw = '0;
   logic [9:0] sw_next = '0;
   logic [7:0] led;
   logic       timer_irq;
`ifdef MEM_IO_BUS_ERR_EN
   logic       bus_err;
`endif

   mem_io_ctrl_if bus();

   always #5 clk = ~clk;

   mem_io_ctrl #(.PRESCALE(P), .RAM_TOP(9'h0FF)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .bus       (bus),
      .sw        (sw),
      .led       (led),
      .timer_irq (timer_irq)
`ifdef MEM_IO_BUS_ERR_EN
      ,
      .bus_err   (bus_err)
`endif
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] rd;
      logic        we;
      logic [7:0]  ra;
      logic [15:0] wdat;
      logic [7:0]  led;
      logic        irq;
      logic        berr;
   } exp_t;
   exp_t sbq[$];

   // Behavioural model state
   logic [7:0]  m_led;
   logic [15:0] m_tload, m_tcount;
   int          m_presc;
   bit          m_run, m_reload, m_exp, m_berr;
   logic [9:0]  m_sw1, m_sw2;

   task automatic model_reset();
      m_led = '0; m_tload = '0; m_tcount = '0; m_presc = 0;
      m_run = 0; m_reload = 0; m_exp = 0; m_berr = 0;
      m_sw1 = '0; m_sw2 = '0;
   endtask

   function automatic logic [15:0] model_read(input logic [8:0] a, input logic [15:0] rr);
      if (a <= 9'h0FF) return rr;
      case (a)
         9'h100:  return {8'h00, m_led};
         9'h101:  return m_tload;
         9'h102:  return m_tcount;
         9'h103:  return {13'h0000, m_berr, m_run, m_exp};
         9'h140:  return {6'h00, m_sw2};
         default: return 16'h0000;
      endcase
   endfunction

   // True when the coming clock edge will make the timer expire (if not stopped).
   function automatic bit expiry_next();
      logic [15:0] cur;
      cur = m_reload ? m_tload : m_tcount;
      return m_run && (m_presc == P - 1) && (cur <= 16'd1);
   endfunction

   task automatic model_step(input logic rn, input logic [1:0] cmd,
                             input logic [8:0] addr, input logic [15:0] wd);
      bit wr, reg_wr, set, tick;
      logic [15:0] cur;
      if (!rn) begin
         model_reset();
         return;
      end
      wr     = (cmd == 2'b10);
      reg_wr = wr && (addr > 9'h0FF);
`ifdef MEM_IO_BUS_ERR_EN
      if ((cmd == 2'b01 || wr) &&
          !(addr <= 9'h0FF || addr inside {9'h100, 9'h101, 9'h102, 9'h103, 9'h140}))
         m_berr = 1;
      if (wr && (addr == 9'h102 || addr == 9'h140)) m_berr = 1;
`endif
      set = 0;
      if (m_run) begin
         if (reg_wr && addr == 9'h103 && !wd[1]) begin
            m_run = 0; m_reload = 0;
         end else begin
            tick     = (m_presc == P - 1);
            m_presc  = tick ? 0 : m_presc + 1;
            cur      = m_reload ? m_tload : m_tcount;
            m_reload = 0;
            if (tick && cur <= 16'd1) begin
               m_tcount = '0; set = 1; m_reload = 1;
            end else begin
               m_tcount = tick ? 16'(cur - 16'd1) : cur;
            end
         end
      end else if (reg_wr && addr == 9'h103 && wd[1]) begin
         m_run = 1; m_presc = 0;
         if (m_tload == '0) begin
            m_tcount = '0; set = 1; m_reload = 1;
         end else begin
            m_tcount = m_tload; m_reload = 0;
         end
      end
      if (set) m_exp = 1;
      else if (reg_wr && addr == 9'h103 && wd[0]) m_exp = 0;
      if (reg_wr && addr == 9'h100) m_led = wd[7:0];
      if (reg_wr && addr == 9'h101) m_tload = wd;
      m_sw2 = m_sw1;
      m_sw1 = sw;
   endtask

   task automatic drive(input logic rn, input logic [1:0] cmd,
                        input logic [8:0] addr, input logic [15:0] wd);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n          = rn;
      sw             = sw_next;
      bus.mem_cmd    = cmd;
      bus.mem_addr   = addr;
      bus.write_data = wd;
      bus.ram_rdata  = 16'($urandom);
      e.rd   = (cmd == 2'b01) ? model_read(addr, bus.ram_rdata) : 16'h0000;
      e.we   = (cmd == 2'b10) && (addr <= 9'h0FF);
      e.ra   = addr[7:0];
      e.wdat = wd;
      e.led  = m_led;
      e.irq  = m_exp;
      e.berr = m_berr;
      sbq.push_back(e);
      model_step(rn, cmd, addr, wd);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("read_data", bus.read_data, e.rd);
            chk("ram_we",    16'(bus.ram_we), 16'(e.we));
            chk("ram_addr",  16'(bus.ram_addr), 16'(e.ra));
            chk("ram_wdata", bus.ram_wdata, e.wdat);
            chk("led",       16'(led), 16'(e.led));
            chk("timer_irq", 16'(timer_irq), 16'(e.irq));
`ifdef MEM_IO_BUS_ERR_EN
            chk("bus_err",   16'(bus_err), 16'(e.berr));
`endif
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] wd;
      bus.mem_cmd = '0; bus.mem_addr = '0; bus.write_data = '0; bus.ram_rdata = '0;
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      drive(1, 2'b01, 9'h103, 16'h0);
      drive(1, 2'b01, 9'h102, 16'h0);
      drive(1, 2'b01, 9'h100, 16'h0);
      // LED and RAM write
      drive(1, 2'b10, 9'h100, 16'hA5C3);
      drive(1, 2'b01, 9'h100, 16'h0);
      drive(1, 2'b10, 9'h040, 16'h1234);
      // Switch synchronizer latency
      sw_next = 10'h2AA;
      repeat (4) drive(1, 2'b01, 9'h140, 16'h0);
      // Timer: TLOAD=3, start, observe countdown, expiry and reload
      drive(1, 2'b10, 9'h101, 16'h0003);
      drive(1, 2'b10, 9'h103, 16'h0002);
      repeat (16) drive(1, 2'b01, 9'h102, 16'h0);
      drive(1, 2'b10, 9'h103, 16'h0003);
      repeat (3) drive(1, 2'b01, 9'h103, 16'h0);
      // Clear-write landing on an expiry edge
      for (int i = 0; i < 60 && !expiry_next(); i++) drive(1, 2'b01, 9'h102, 16'h0);
      drive(1, 2'b10, 9'h103, 16'h0003);
      drive(1, 2'b01, 9'h103, 16'h0);
      // TLOAD=0 start expires immediately
      drive(1, 2'b10, 9'h103, 16'h0000);
      drive(1, 2'b10, 9'h103, 16'h0001);
      drive(1, 2'b10, 9'h101, 16'h0000);
      drive(1, 2'b10, 9'h103, 16'h0002);
      drive(1, 2'b01, 9'h103, 16'h0);
      drive(1, 2'b01, 9'h102, 16'h0);
      // Unmapped access
      drive(1, 2'b01, 9'h1F0, 16'h0);
      drive(1, 2'b01, 9'h103, 16'h0);
      drive(1, 2'b01, 9'h103, 16'h0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: cmd = 2'b01;
            4, 5, 6:    cmd = 2'b10;
            7, 8:       cmd = 2'b00;
            default:    cmd = 2'b11;
         endcase
         case ($urandom_range(0, 9))
            0, 1:    addr = {1'b0, 8'($urandom)};
            2:       addr = 9'h100;
            3:       addr = 9'h101;
            4, 5:    addr = 9'h102;
            6:       addr = 9'h103;
            7:       addr = 9'h140;
            8:       addr = 9'($urandom_range(9'h104, 9'h1FF));
            default: addr = 9'h1F0;
         endcase
         if (addr == 9'h103) begin
            case ($urandom_range(0, 5))
               0:       wd = 16'h0000;
               1:       wd = 16'h0001;
               2, 3:    wd = 16'h0002;
               default: wd = 16'h0003;
            endcase
         end else if (addr == 9'h101) begin
            wd = 16'($urandom_range(0, 5));
         end else begin
            wd = 16'($urandom);
         end
         if ($urandom_range(0, 7) == 0) sw_next = 10'($urandom);
         if ($urandom_range(0, 249) == 0) drive(0, 2'b10, addr, wd);
         else drive(1, cmd, addr, wd);
      end
      drive(1, 2'b00, 9'h000, 16'h0);

      @(negedge clk);
      for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
      if (sbq.size() > 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
